barcode_reader: RTL and testbench

Serial barcode decoder for the Follower. Takes the asynchronous `BC` line from the optical barcode sensor (stimulated in simulation by `barcode_mimic`), recovers the bit timing from the start bit, and shifts out an 8-bit station ID. A completed, well-formed ID is presented on `ID` with `ID_vld` held high until the command/navigation logic clears it; that logic uses it to decide whether the robot has reached its commanded destination.

---
 rtl/barcode_reader.sv | 158 +++++++++++++++
 tb/tb_barcode_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/barcode_reader.sv
// Serial barcode decoder.
// Recovers bit timing from the start-bit low width and shifts in an 8-bit
// station ID, MSB first. A well-formed ID (upper two bits zero) is latched
// on ID with a sticky ID_vld flag until the consumer pulses clr_ID_vld.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   BC         raw barcode line, asynchronous, idle high
//   clr_ID_vld single-cycle clear of ID_vld (a simultaneous set wins)
//   ID         last valid station ID
//   ID_vld     sticky "new ID held" flag
module barcode_reader #(
  parameter int unsigned CNT_W = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld
);

  typedef enum logic [2:0] {
    StIdle,
    StStartLow,
    StWaitFall,
    StSample,
    StCheck
  } state_e;

  state_e state_q, state_d;

  logic             bc_meta_q, bc_sync_q, bc_hist_q;
  logic [1:0]       flush_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] start_w_q, start_w_d;
  logic [7:0]       shft_q, shft_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       id_q, id_d;
  logic             id_vld_q, id_vld_d;

  logic             fall;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W:0]   wait_lim;
  logic             wait_expired;

  // Edges are only honoured once the synchronizer holds real line data and
  // the line has been seen high; a reset while BC is low therefore cannot
  // fake a falling edge in the middle of a frame.
  assign fall         = armed_q & bc_hist_q & ~bc_sync_q;
  assign cnt_sat      = (cnt_q == {CNT_W{1'b1}});
  assign cnt_inc      = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
  assign wait_lim     = {start_w_q, 1'b0};
  assign wait_expired = ({1'b0, cnt_q} >= wait_lim);

  always_ff @(posedge clk) begin
    if (rst) begin
      bc_meta_q <= 1'b1;
      bc_sync_q <= 1'b1;
      bc_hist_q <= 1'b1;
      flush_q   <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      bc_meta_q <= BC;
      bc_sync_q <= bc_meta_q;
      bc_hist_q <= bc_sync_q;
      flush_q   <= {flush_q[0], 1'b1};
      if (flush_q[1] && bc_sync_q) armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      start_w_q <= '0;
      shft_q    <= '0;
      bit_cnt_q <= '0;
      id_q      <= '0;
      id_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_w_q <= start_w_d;
      shft_q    <= shft_d;
      bit_cnt_q <= bit_cnt_d;
      id_q      <= id_d;
      id_vld_q  <= id_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_w_d = start_w_q;
    shft_d    = shft_q;
    bit_cnt_d = bit_cnt_q;
    id_d      = id_q;
    id_vld_d  = id_vld_q & ~clr_ID_vld;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fall) begin
          // The recognising cycle is itself low time, so start_w is never 0.
          cnt_d   = CNT_W'(1);
          state_d = StStartLow;
        end
      end
      StStartLow: begin
        if (bc_sync_q) begin
          start_w_d = cnt_q;
          bit_cnt_d = '0;
          cnt_d     = '0;
          state_d   = StWaitFall;
        end else if (cnt_sat) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitFall: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = StSample;
        end else if (wait_expired) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StSample: begin
        cnt_d = cnt_inc;
        if (cnt_q == start_w_q) begin
          shft_d    = {shft_q[6:0], bc_sync_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
          cnt_d     = '0;
          state_d   = (bit_cnt_q == 4'd7) ? StCheck : StWaitFall;
        end
      end
      StCheck: begin
        if (shft_q[7:6] == 2'b00) begin
          id_d     = shft_q;
          id_vld_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ID     = id_q;
  assign ID_vld = id_vld_q;

endmodule

// File: tb/tb_barcode_reader.sv
// Bench for barcode_reader: drives line-coded frames, keeps an outcome model
// (what ID/ID_vld must hold after each frame, clear and reset) and compares
// the DUT against it every cycle, plus literal checks at key points.
module tb_barcode_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       bc;
  logic       clr;
  logic [7:0] id;
  logic       id_vld;

  barcode_reader #(.CNT_W(22)) dut (
    .clk       (clk),
    .rst       (rst),
    .BC        (bc),
    .clr_ID_vld(clr),
    .ID        (id),
    .ID_vld    (id_vld)
  );

  always #10 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  bit         checking    = 1'b0;
  logic [7:0] m_id, p_id;
  logic       m_vld;
  bit         pending;
  logic       vld_prev;
  int         rise_cyc, fall_cyc;

  task automatic lit(input string name, input logic [7:0] eid, input logic ev);
    #1;
    vectors++;
    if (id !== eid || id_vld !== ev) begin
      miscompares++;
      $display("FAIL %s: ID=%h ID_vld=%b, expected ID=%h ID_vld=%b", name, id, id_vld, eid, ev);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    vectors++;
    if (got < lo || got > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // One clock: compare mid-cycle, drive inputs, then advance the model at the edge.
  task automatic tick(input logic b, input logic c, input logic r);
    @(negedge clk);
    if (checking) begin
      vectors++;
      if (!((id === m_id && id_vld === m_vld) || (pending && id === p_id && id_vld === 1'b1)))
      begin
        miscompares++;
        if (miscompares <= 20)
          $display("FAIL cycle %0d: ID=%h ID_vld=%b, expected ID=%h ID_vld=%b", cyc, id, id_vld,
                   m_id, m_vld);
      end
      if (id_vld === 1'b1 && vld_prev !== 1'b1) rise_cyc = cyc;
      vld_prev = id_vld;
    end
    bc  = b;
    clr = c;
    rst = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_id    = 8'h00;
      m_vld   = 1'b0;
      pending = 1'b0;
    end else if (c) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic gap(input int n, input bit rand_clr);
    for (int i = 0; i < n; i++) tick(1'b1, rand_clr && ($urandom_range(0, 7) == 0), 1'b0);
  endtask

  // Start bit low T/2, data '1' low T/4, data '0' low 3T/4, each bit T long.
  task automatic send_frame(input logic [7:0] v, input int t, input int nbits,
                            input int rst_bit, input bit clr_coin);
    int low;
    for (int k = 0; k < t; k++) tick((k < t / 2) ? 1'b0 : 1'b1, 1'b0, 1'b0);
    for (int b = 0; b < nbits; b++) begin
      low = v[7-b] ? t / 4 : (3 * t) / 4;
      if (b == 7) begin
        fall_cyc = cyc;
        if (v[7:6] == 2'b00 && rst_bit < 0) begin
          pending = 1'b1;
          p_id    = v;
        end
      end
      for (int k = 0; k < t; k++)
        tick((k < low) ? 1'b0 : 1'b1,
             (clr_coin && b == 7 && k == t / 2 + 4) ? 1'b1 : 1'b0,
             (b == rst_bit && k == low / 2) ? 1'b1 : 1'b0);
    end
    if (pending) begin
      m_id    = p_id;
      m_vld   = 1'b1;
      pending = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] v;
    int         t;
    bc       = 1'b1;
    clr      = 1'b0;
    rst      = 1'b1;
    m_id     = 8'h00;
    m_vld    = 1'b0;
    p_id     = 8'h00;
    pending  = 1'b0;
    vld_prev = 1'b0;
    rise_cyc = -1;
    fall_cyc = 0;

    tick(1'b1, 1'b0, 1'b1);
    checking = 1'b1;
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    lit("reset", 8'h00, 1'b0);
    gap(20, 1'b0);

    // Single valid frame at the nominal period; flag rises ~start_w after the last fall.
    send_frame(8'h01, 'h1000, 8, -1, 1'b0);
    lit("frame_01", 8'h01, 1'b1);
    check_range("vld_latency", rise_cyc - fall_cyc, 'h800, 'h800 + 10);
    gap(1000, 1'b0);
    lit("hold_01", 8'h01, 1'b1);

    send_frame(8'h02, 'h80, 8, -1, 1'b0);
    lit("frame_02", 8'h02, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    lit("clear", 8'h02, 1'b0);
    gap(20, 1'b0);
    send_frame(8'h3F, 'h80, 8, -1, 1'b0);
    lit("frame_3f", 8'h3F, 1'b1);
    gap(20, 1'b0);

    // Clear lands on the same edge as the set: the set must win.
    send_frame(8'h05, 'h80, 8, -1, 1'b1);
    lit("clr_vs_set", 8'h05, 1'b1);
    gap(20, 1'b0);
    send_frame(8'hC5, 'h80, 8, -1, 1'b0);
    lit("upper_bits", 8'h05, 1'b1);
    gap(20, 1'b0);

    send_frame(8'hA5, 'h200, 8, -1, 1'b0);
    lit("frame_a5", 8'h05, 1'b1);
    gap(20, 1'b0);
    send_frame(8'h2A, 'h200, 8, -1, 1'b0);
    lit("frame_2a_200", 8'h2A, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    gap(20, 1'b0);
    send_frame(8'h2A, 'hFF, 8, -1, 1'b0);
    lit("frame_2a_ff", 8'h2A, 1'b1);
    gap(20, 1'b0);

    // Truncated frame must time out without touching the outputs.
    send_frame(8'h3C, 'h80, 4, -1, 1'b0);
    gap(2 * 'h80 + 100, 1'b0);
    lit("truncated", 8'h2A, 1'b1);
    send_frame(8'h11, 'h80, 8, -1, 1'b0);
    lit("frame_11", 8'h11, 1'b1);
    gap(20, 1'b0);

    // Reset during bit 3; the tail of that frame must not produce an ID.
    send_frame(8'h15, 'h80, 8, 3, 1'b0);
    lit("rst_mid_frame", 8'h00, 1'b0);
    gap(3 * 'h80, 1'b0);
    lit("rst_tail", 8'h00, 1'b0);
    send_frame(8'h15, 'h80, 8, -1, 1'b0);
    lit("frame_15", 8'h15, 1'b1);
    gap(20, 1'b0);

    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 1) == 1) v[7:6] = 2'b00;
      t = int'($urandom_range('h60, 'hC0));
      send_frame(v, t, 8, -1, 1'b0);
      gap(int'($urandom_range(10, 40)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
